// File: rtl/decode_ctl_if.sv
// Byte-stream input, token output and status bundle
// for the LZS decode control path.
interface decode_ctl_if #(
  parameter int LEN_WIDTH = 12
);
  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 tok_valid;
  logic                 tok_ready;
  logic                 tok_lit;
  logic [7:0]           tok_data;
  logic [10:0]          tok_off;
  logic [LEN_WIDTH-1:0] tok_len;
  logic                 dec_finish;
  logic                 dec_error;

  modport master (
    output in_data, in_valid, tok_ready,
    input  in_ready, tok_valid, tok_lit, tok_data,
    input  tok_off, tok_len, dec_finish, dec_error
  );

  modport slave (
    input  in_data, in_valid, tok_ready,
    output in_ready, tok_valid, tok_lit, tok_data,
    output tok_off, tok_len, dec_finish, dec_error
  );
endinterface

// File: rtl/decode_ctl.sv
// LZS bitstream parser: splits an MSB-first byte stream
// into literal / copy tokens for the decode datapath.
module decode_ctl #(
  parameter int LEN_WIDTH = 12,
  parameter int BUF_WIDTH = 24
) (
  input logic         clk,
  input logic         rst,
  decode_ctl_if.slave bus
);
  localparam int CW = $clog2(BUF_WIDTH + 1);
  localparam int T  = BUF_WIDTH - 1;

  typedef enum logic [2:0] {
    S_TAG, S_LEN, S_EXT, S_EMIT, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;

  logic [BUF_WIDTH-1:0] buf_q, buf_d;
  logic [BUF_WIDTH-1:0] buf_sh, app;
  logic [CW-1:0]        bcnt_q, bcnt_d;
  logic [CW-1:0]        cons, cnt_sh;

  logic                 tok_lit_q, tok_lit_d;
  logic [7:0]           tok_data_q, tok_data_d;
  logic [10:0]          tok_off_q, tok_off_d;
  logic [LEN_WIDTH-1:0] tok_len_q, tok_len_d;
  logic [LEN_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH:0]   sum;

  logic [1:0]  top2;
  logic [3:0]  top4;
  logic [6:0]  off7;
  logic [10:0] off11;
  logic        take;

  // Oldest stream bit sits at buf_q[T]
  assign top2  = buf_q[T -: 2];
  assign top4  = buf_q[T -: 4];
  assign off7  = buf_q[T-2 -: 7];
  assign off11 = buf_q[T-2 -: 11];

  assign sum = {1'b0, acc_q}
             + {{(LEN_WIDTH-3){1'b0}}, top4};

  assign bus.in_ready = (bcnt_q <= CW'(BUF_WIDTH - 8))
                     && state_q != S_DONE
                     && state_q != S_ERR;
  assign take = bus.in_valid && bus.in_ready;

  assign bus.tok_valid  = state_q == S_EMIT;
  assign bus.tok_lit    = tok_lit_q;
  assign bus.tok_data   = tok_data_q;
  assign bus.tok_off    = tok_off_q;
  assign bus.tok_len    = tok_len_q;
  assign bus.dec_finish = state_q == S_DONE;
  assign bus.dec_error  = state_q == S_ERR;

  always_comb begin
    state_d    = state_q;
    cons       = '0;
    tok_lit_d  = tok_lit_q;
    tok_data_d = tok_data_q;
    tok_off_d  = tok_off_q;
    tok_len_d  = tok_len_q;
    acc_d      = acc_q;
    unique case (state_q)
      S_TAG: begin
        if (bcnt_q >= CW'(9)) begin
          if (!buf_q[T]) begin
            cons       = CW'(9);
            tok_lit_d  = 1'b1;
            tok_data_d = buf_q[T-1 -: 8];
            tok_off_d  = '0;
            tok_len_d  = '0;
            state_d    = S_EMIT;
          end else if (buf_q[T-1]) begin
            cons = CW'(9);
            if (off7 == 7'd0) begin
              state_d = S_DONE;
            end else begin
              tok_lit_d  = 1'b0;
              tok_data_d = '0;
              tok_off_d  = {4'd0, off7};
              tok_len_d  = '0;
              state_d    = S_LEN;
            end
          end else if (bcnt_q >= CW'(13)) begin
            cons = CW'(13);
            if (off11 == 11'd0) begin
              state_d = S_ERR;
            end else begin
              tok_lit_d  = 1'b0;
              tok_data_d = '0;
              tok_off_d  = off11;
              tok_len_d  = '0;
              state_d    = S_LEN;
            end
          end
        end
      end
      S_LEN: begin
        unique case (1'b1)
          top2 != 2'b11 && bcnt_q >= CW'(2): begin
            cons      = CW'(2);
            tok_len_d = LEN_WIDTH'(2) + LEN_WIDTH'(top2);
            state_d   = S_EMIT;
          end
          top2 == 2'b11 && top4 != 4'hF
            && bcnt_q >= CW'(4): begin
            cons      = CW'(4);
            tok_len_d = LEN_WIDTH'(5) + LEN_WIDTH'(top4[1:0]);
            state_d   = S_EMIT;
          end
          top4 == 4'hF && bcnt_q >= CW'(4): begin
            cons    = CW'(4);
            acc_d   = LEN_WIDTH'(8);
            state_d = S_EXT;
          end
          default: ;
        endcase
      end
      S_EXT: begin
        if (bcnt_q >= CW'(4)) begin
          cons = CW'(4);
          if (sum[LEN_WIDTH]) begin
            state_d = S_ERR;
          end else if (top4 == 4'hF) begin
            acc_d = sum[LEN_WIDTH-1:0];
          end else begin
            tok_len_d = sum[LEN_WIDTH-1:0];
            state_d   = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (bus.tok_ready) state_d = S_TAG;
      end
      S_DONE: ;
      S_ERR:  ;
      default: state_d = S_ERR;
    endcase
  end

  // New byte lands directly below the bits left after consumption
  always_comb begin
    cnt_sh = bcnt_q - cons;
    buf_sh = buf_q << cons;
    app    = {bus.in_data, {(BUF_WIDTH-8){1'b0}}} >> cnt_sh;
    buf_d  = take ? (buf_sh | app) : buf_sh;
    bcnt_d = take ? cnt_sh + CW'(8) : cnt_sh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_TAG;
      buf_q      <= '0;
      bcnt_q     <= '0;
      tok_lit_q  <= 1'b0;
      tok_data_q <= '0;
      tok_off_q  <= '0;
      tok_len_q  <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      bcnt_q     <= bcnt_d;
      tok_lit_q  <= tok_lit_d;
      tok_data_q <= tok_data_d;
      tok_off_q  <= tok_off_d;
      tok_len_q  <= tok_len_d;
      acc_q      <= acc_d;
    end
  end
endmodule

// File: tb/tb_decode_ctl.sv
// Directed bench for decode_ctl: token streams, stalls,
// protocol error and reset recovery.
module tb_decode_ctl;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  decode_ctl_if #(.LEN_WIDTH(12)) bus ();

  decode_ctl #(
    .LEN_WIDTH(12),
    .BUF_WIDTH(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic        lit;
    logic [7:0]  data;
    logic [10:0] off;
    logic [11:0] len;
  } tok_t;
  typedef tok_t tq_t [$];

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic tok_t mk(input logic l,
                              input logic [7:0] d,
                              input logic [10:0] o,
                              input logic [11:0] n);
    return {l, d, o, n};
  endfunction

  function automatic logic [31:0] cur_tok();
    return {bus.tok_lit, bus.tok_data, bus.tok_off, bus.tok_len};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic feed(input bq_t b, input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          bus.in_valid = 1'b0;
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b[i];
      for (int t = 0; t < 200 && !bus.in_ready; t++)
        @(negedge clk);
      if (!bus.in_ready) begin
        check("in_timeout", 32'(bus.in_ready), 1);
        break;
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic consume(input tq_t e, input bit stall);
    foreach (e[k]) begin
      for (int t = 0; t < 400 && !bus.tok_valid; t++)
        @(negedge clk);
      check("tok_valid", 32'(bus.tok_valid), 1);
      if (!bus.tok_valid) return;
      check("tok_fields", cur_tok(), e[k]);
      if (stall) begin
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_valid", 32'(bus.tok_valid), 1);
          check("stall_fields", cur_tok(), e[k]);
        end
      end
      bus.tok_ready = 1'b1;
      @(negedge clk);
      bus.tok_ready = 1'b0;
      check("tok_drop", 32'(bus.tok_valid), 0);
    end
  endtask

  task automatic run(input string nm, input bq_t b,
                     input tq_t e, input bit gaps,
                     input bit stall);
    fork
      feed(b, gaps);
      consume(e, stall);
    join
    for (int t = 0; t < 200 && !bus.dec_finish; t++)
      @(negedge clk);
    check({nm, "_finish"}, 32'(bus.dec_finish), 1);
    check({nm, "_in_ready"}, 32'(bus.in_ready), 0);
    check({nm, "_tok_valid"}, 32'(bus.tok_valid), 0);
    check({nm, "_error"}, 32'(bus.dec_error), 0);
  endtask

  bq_t b_lit, b_short, b_long16, b_long128;
  bq_t b_len7, b_multi, b_err, b_ext;
  tq_t e_lit, e_short, e_long16, e_long128;
  tq_t e_len7, e_multi;

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.tok_ready = 1'b0;

    b_lit     = '{8'h20, 8'hE0, 8'h00};
    b_short   = '{8'hC2, 8'h98, 8'h00};
    b_long16  = '{8'h80, 8'h87, 8'hF9, 8'hE0, 8'h00};
    b_long128 = '{8'h84, 8'h07, 8'hF9, 8'hE0, 8'h00};
    b_len7    = '{8'hC0, 8'hF6, 8'h00};
    b_multi   = '{8'h20, 8'hE1, 8'h4C, 8'h00};
    b_err     = '{8'h80, 8'h00};
    b_ext     = '{8'h80, 8'h87, 8'hF9};

    e_lit.push_back(mk(1'b1, 8'h41, 11'd0, 12'd0));
    e_short.push_back(mk(1'b0, 8'h00, 11'd5, 12'd2));
    e_long16.push_back(mk(1'b0, 8'h00, 11'd16, 12'd26));
    e_long128.push_back(mk(1'b0, 8'h00, 11'd128, 12'd26));
    e_len7.push_back(mk(1'b0, 8'h00, 11'd1, 12'd7));
    e_multi.push_back(mk(1'b1, 8'h41, 11'd0, 12'd0));
    e_multi.push_back(mk(1'b0, 8'h00, 11'd5, 12'd2));

    repeat (2) @(negedge clk);
    check("rst_tok_valid", 32'(bus.tok_valid), 0);
    check("rst_fields", cur_tok(), 0);
    check("rst_finish", 32'(bus.dec_finish), 0);
    check("rst_error", 32'(bus.dec_error), 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 1);

    run("lit", b_lit, e_lit, 1'b0, 1'b0);
    do_reset();
    run("short", b_short, e_short, 1'b0, 1'b0);
    do_reset();
    run("long16", b_long16, e_long16, 1'b0, 1'b0);
    do_reset();
    run("long128", b_long128, e_long128, 1'b0, 1'b0);
    do_reset();
    run("len7", b_len7, e_len7, 1'b0, 1'b0);
    do_reset();
    run("multi_bp", b_multi, e_multi, 1'b1, 1'b1);
    do_reset();
    run("long_bp", b_long16, e_long16, 1'b1, 1'b1);
    do_reset();
    run("short_bp", b_short, e_short, 1'b1, 1'b1);

    do_reset();
    feed(b_err, 1'b0);
    for (int t = 0; t < 50 && !bus.dec_error; t++)
      @(negedge clk);
    check("err_flag", 32'(bus.dec_error), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h20;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("err_in_ready", 32'(bus.in_ready), 0);
      check("err_tok_valid", 32'(bus.tok_valid), 0);
    end
    bus.in_valid = 1'b0;
    check("err_finish", 32'(bus.dec_finish), 0);
    check("err_sticky", 32'(bus.dec_error), 1);

    do_reset();
    feed(b_ext, 1'b0);
    repeat (4) @(negedge clk);
    check("ext_no_tok", 32'(bus.tok_valid), 0);
    check("ext_no_fin", 32'(bus.dec_finish), 0);
    do_reset();
    check("ext_rst_fields", cur_tok(), 0);
    check("ext_rst_ready", 32'(bus.in_ready), 1);
    run("after_rst", b_lit, e_lit, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
